// File: rtl/axi_r_spill_fifo.sv
// N-deep elastic buffer for AXI R beats with flush, occupancy count and optional bypass.
// Define AXI_R_SPILL_FIFO_LAST_CNT_EN to add last_cnt_o (stored beats with last = 1).
module axi_r_spill_fifo #(
    parameter int IdWidth   = 0,
    parameter int DataWidth = 0,
    parameter int UserWidth = 0,
    parameter int Depth     = 2,
    parameter int Bypass    = 0,
    localparam int W  = IdWidth + DataWidth + 3 + UserWidth,
    localparam int CW = $clog2(Depth + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [W-1:0]  data_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] count_o
`ifdef AXI_R_SPILL_FIFO_LAST_CNT_EN
    ,
    output logic [CW-1:0] last_cnt_o
`endif
);

    localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

    generate
        if (Bypass != 0) begin : g_bypass
            assign valid_o = valid_i && !flush_i;
            assign ready_o = ready_i && !flush_i;
            assign data_o  = data_i;
            assign count_o = '0;
`ifdef AXI_R_SPILL_FIFO_LAST_CNT_EN
            assign last_cnt_o = '0;
`endif
        end else begin : g_fifo
            logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
            logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
            logic [CW-1:0] cnt_reg, cnt_next;
            logic [W-1:0]  mem [Depth];
            logic          push;
            logic          pop;

            // Pointers wrap explicitly so Depth need not be a power of two.
            function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
                return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
            endfunction

            assign ready_o = (cnt_reg != CW'(Depth)) && !flush_i;
            assign valid_o = (cnt_reg != '0) && !flush_i;
            assign push    = valid_i && ready_o;
            assign pop     = valid_o && ready_i;
            assign data_o  = mem[rd_ptr_reg];
            assign count_o = cnt_reg;

            always_comb begin
                wr_ptr_next = wr_ptr_reg;
                rd_ptr_next = rd_ptr_reg;
                cnt_next    = cnt_reg;
                if (push) begin
                    wr_ptr_next = ptr_inc(wr_ptr_reg);
                end
                if (pop) begin
                    rd_ptr_next = ptr_inc(rd_ptr_reg);
                end
                case ({push, pop})
                    2'b10:   cnt_next = cnt_reg + 1'b1;
                    2'b01:   cnt_next = cnt_reg - 1'b1;
                    default: cnt_next = cnt_reg;
                endcase
            end

            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    cnt_reg    <= '0;
                end else begin
                    wr_ptr_reg <= wr_ptr_next;
                    rd_ptr_reg <= rd_ptr_next;
                    cnt_reg    <= cnt_next;
                end
            end

            // Storage is never cleared; push is already blocked during flush.
            for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
                always_ff @(posedge clk_i) begin
                    if (push && (wr_ptr_reg == PW'(gi))) begin
                        mem[gi] <= data_i;
                    end
                end
            end

`ifdef AXI_R_SPILL_FIFO_LAST_CNT_EN
            logic [CW-1:0] last_cnt_reg, last_cnt_next;
            logic          push_last;
            logic          pop_last;

            assign push_last  = push && data_i[UserWidth];
            assign pop_last   = pop && data_o[UserWidth];
            assign last_cnt_o = last_cnt_reg;

            always_comb begin
                last_cnt_next = last_cnt_reg;
                case ({push_last, pop_last})
                    2'b10:   last_cnt_next = last_cnt_reg + 1'b1;
                    2'b01:   last_cnt_next = last_cnt_reg - 1'b1;
                    default: last_cnt_next = last_cnt_reg;
                endcase
            end

            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    last_cnt_reg <= '0;
                end else begin
                    last_cnt_reg <= last_cnt_next;
                end
            end
`endif
        end
    endgenerate

endmodule
